// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle of stall/flush requests, fetch/decode inputs and the registered
// pipeline state exported by pipeline_stall_ctrl.
// Handshake: there is no valid/ready pair here; stall and flush are level
// requests sampled on every rising clk edge, and every output is a flop.
interface pipeline_stall_ctrl_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               stall;
    logic               flush;
    logic [PC_W-1:0]    flush_target;
    logic [INSTR_W-1:0] imem_instr;
    logic               id_mem_read;
    logic               id_reg_write;
    logic [1:0]         id_dest_reg;
    logic [1:0]         id_src_reg1;
    logic [1:0]         id_src_reg2;

    logic [PC_W-1:0]    pc;
    logic               ifid_valid;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc;
    logic               ex_valid;
    logic               ex_mem_read;
    logic               ex_reg_write;
    logic [1:0]         ex_dest_reg;
    logic [1:0]         ex_src_reg1;
    logic [1:0]         ex_src_reg2;
    logic [7:0]         bubble_count;
    logic               protocol_err;

    // Environment side: hazard unit, branch unit, instruction memory, decoder.
    modport master (
        output stall, flush, flush_target, imem_instr,
        output id_mem_read, id_reg_write, id_dest_reg, id_src_reg1, id_src_reg2,
        input  pc, ifid_valid, ifid_instr, ifid_pc,
        input  ex_valid, ex_mem_read, ex_reg_write, ex_dest_reg, ex_src_reg1, ex_src_reg2,
        input  bubble_count, protocol_err
    );

    // Controller side.
    modport slave (
        input  stall, flush, flush_target, imem_instr,
        input  id_mem_read, id_reg_write, id_dest_reg, id_src_reg1, id_src_reg2,
        output pc, ifid_valid, ifid_instr, ifid_pc,
        output ex_valid, ex_mem_read, ex_reg_write, ex_dest_reg, ex_src_reg1, ex_src_reg2,
        output bubble_count, protocol_err
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Front-end pipeline control: owns the PC, the IF/ID and ID/EX registers,
// inserts bubbles on load-use stalls, squashes on flush, counts stall
// bubbles and flags stalls that have no load sitting in EX.
module pipeline_stall_ctrl #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
) (
    input logic                clk,
    input logic                rst,
    pipeline_stall_ctrl_if.slave bus
);
    logic [PC_W-1:0]    pc_q,           pc_d;
    logic               ifid_valid_q,   ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q,   ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_q,      ifid_pc_d;
    logic               ex_valid_q,     ex_valid_d;
    logic               ex_mem_read_q,  ex_mem_read_d;
    logic               ex_reg_write_q, ex_reg_write_d;
    logic [1:0]         ex_dest_reg_q,  ex_dest_reg_d;
    logic [1:0]         ex_src_reg1_q,  ex_src_reg1_d;
    logic [1:0]         ex_src_reg2_q,  ex_src_reg2_d;
    logic [7:0]         bubble_count_q, bubble_count_d;
    logic               protocol_err_q, protocol_err_d;

    // Next-state: flush beats stall; both bubble ID/EX, only stall holds IF.
    always_comb begin
        pc_d           = pc_q;
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ex_valid_d     = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_dest_reg_d  = 2'd0;
        ex_src_reg1_d  = 2'd0;
        ex_src_reg2_d  = 2'd0;
        bubble_count_d = bubble_count_q;
        protocol_err_d = protocol_err_q;

        if (bus.flush) begin
            pc_d         = bus.flush_target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            ifid_pc_d    = '0;
        end else if (bus.stall) begin
            if (bubble_count_q != 8'hFF) begin
                bubble_count_d = bubble_count_q + 8'd1;
            end
            // A legal load-use stall only happens while the load sits in EX.
            if (!ex_mem_read_q) begin
                protocol_err_d = 1'b1;
            end
        end else begin
            pc_d         = pc_q + 1'b1;
            ifid_valid_d = 1'b1;
            ifid_instr_d = bus.imem_instr;
            ifid_pc_d    = pc_q;
            if (ifid_valid_q) begin
                ex_valid_d     = 1'b1;
                ex_mem_read_d  = bus.id_mem_read;
                ex_reg_write_d = bus.id_reg_write;
                ex_dest_reg_d  = bus.id_dest_reg;
                ex_src_reg1_d  = bus.id_src_reg1;
                ex_src_reg2_d  = bus.id_src_reg2;
            end
        end
    end

    // State registers, cleared asynchronously so reset wins mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= '0;
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            ifid_pc_q      <= '0;
            ex_valid_q     <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_dest_reg_q  <= 2'd0;
            ex_src_reg1_q  <= 2'd0;
            ex_src_reg2_q  <= 2'd0;
            bubble_count_q <= 8'd0;
            protocol_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ex_valid_q     <= ex_valid_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_dest_reg_q  <= ex_dest_reg_d;
            ex_src_reg1_q  <= ex_src_reg1_d;
            ex_src_reg2_q  <= ex_src_reg2_d;
            bubble_count_q <= bubble_count_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.ifid_valid   = ifid_valid_q;
    assign bus.ifid_instr   = ifid_instr_q;
    assign bus.ifid_pc      = ifid_pc_q;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_mem_read  = ex_mem_read_q;
    assign bus.ex_reg_write = ex_reg_write_q;
    assign bus.ex_dest_reg  = ex_dest_reg_q;
    assign bus.ex_src_reg1  = ex_src_reg1_q;
    assign bus.ex_src_reg2  = ex_src_reg2_q;
    assign bus.bubble_count = bubble_count_q;
    assign bus.protocol_err = protocol_err_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus a random phase,
// every cycle compared against a cycle-level reference of the pipeline rules.
module tb_pipeline_stall_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipeline_stall_ctrl_if #(.PC_W(8), .INSTR_W(8)) bus ();

    pipeline_stall_ctrl #(.PC_W(8), .INSTR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference pipeline contents.
    logic [7:0] m_pc, m_ifi, m_ifp, m_cnt;
    logic       m_ifv, m_exv, m_exmr, m_exrw, m_err;
    logic [1:0] m_exd, m_exs1, m_exs2;

    task automatic model_reset();
        m_pc = 0; m_ifv = 0; m_ifi = 0; m_ifp = 0;
        m_exv = 0; m_exmr = 0; m_exrw = 0; m_exd = 0; m_exs1 = 0; m_exs2 = 0;
        m_cnt = 0; m_err = 0;
    endtask

    // Apply one rising edge worth of pipeline rules to the reference.
    task automatic model_step();
        logic       was_valid;
        int         nxt_cnt;
        was_valid = m_ifv;
        if (bus.flush) begin
            m_pc = bus.flush_target;
            m_ifv = 0; m_ifi = 0; m_ifp = 0;
            m_exv = 0; m_exmr = 0; m_exrw = 0; m_exd = 0; m_exs1 = 0; m_exs2 = 0;
        end else if (bus.stall) begin
            if (m_exmr == 1'b0) m_err = 1'b1;
            nxt_cnt = int'(m_cnt) + 1;
            m_cnt = (nxt_cnt > 255) ? 8'd255 : 8'(nxt_cnt);
            m_exv = 0; m_exmr = 0; m_exrw = 0; m_exd = 0; m_exs1 = 0; m_exs2 = 0;
        end else begin
            if (was_valid) begin
                m_exv = 1; m_exmr = bus.id_mem_read; m_exrw = bus.id_reg_write;
                m_exd = bus.id_dest_reg; m_exs1 = bus.id_src_reg1; m_exs2 = bus.id_src_reg2;
            end else begin
                m_exv = 0; m_exmr = 0; m_exrw = 0; m_exd = 0; m_exs1 = 0; m_exs2 = 0;
            end
            m_ifv = 1; m_ifi = bus.imem_instr; m_ifp = m_pc;
            m_pc = 8'((int'(m_pc) + 1) % 256);
        end
    endtask

    // Scoreboard comparison primitive.
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},           32'(bus.pc),           32'(m_pc));
        chk({tag, ".ifid_valid"},   32'(bus.ifid_valid),   32'(m_ifv));
        chk({tag, ".ifid_instr"},   32'(bus.ifid_instr),   32'(m_ifi));
        chk({tag, ".ifid_pc"},      32'(bus.ifid_pc),      32'(m_ifp));
        chk({tag, ".ex_valid"},     32'(bus.ex_valid),     32'(m_exv));
        chk({tag, ".ex_mem_read"},  32'(bus.ex_mem_read),  32'(m_exmr));
        chk({tag, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(m_exrw));
        chk({tag, ".ex_dest_reg"},  32'(bus.ex_dest_reg),  32'(m_exd));
        chk({tag, ".ex_src_reg1"},  32'(bus.ex_src_reg1),  32'(m_exs1));
        chk({tag, ".ex_src_reg2"},  32'(bus.ex_src_reg2),  32'(m_exs2));
        chk({tag, ".bubble_count"}, 32'(bus.bubble_count), 32'(m_cnt));
        chk({tag, ".protocol_err"}, 32'(bus.protocol_err), 32'(m_err));
    endtask

    // Driver: set requests, randomize fetch/decode data (optionally force a load).
    task automatic drive(input logic s, input logic f, input logic [7:0] tgt, input logic load);
        bus.stall        = s;
        bus.flush        = f;
        bus.flush_target = tgt;
        bus.imem_instr   = 8'($urandom_range(0, 255));
        bus.id_mem_read  = load ? 1'b1 : 1'($urandom_range(0, 1));
        bus.id_reg_write = 1'($urandom_range(0, 1));
        bus.id_dest_reg  = load ? 2'd2 : 2'($urandom_range(0, 3));
        bus.id_src_reg1  = 2'($urandom_range(0, 3));
        bus.id_src_reg2  = 2'($urandom_range(0, 3));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] seq_exp [4];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        do_reset();

        // Five normal cycles from reset; ex_valid only rises at the second edge.
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick("first_edge");
        chk("first_edge_ex_valid", 32'(bus.ex_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            tick("normal");
        end
        chk("run5_pc", 32'(bus.pc), 32'd5);
        chk("run5_ifid_pc", 32'(bus.ifid_pc), 32'd4);
        chk("run5_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("run5_bubbles", 32'(bus.bubble_count), 32'd0);

        // Legal single-cycle load-use stall.
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick("load_enter");
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick("legal_stall");
        chk("legal_stall_pc", 32'(bus.pc), 32'd6);
        chk("legal_stall_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("legal_stall_bubbles", 32'(bus.bubble_count), 32'd1);
        chk("legal_stall_err", 32'(bus.protocol_err), 32'd0);

        // Stall and flush together: flush wins, bubble count unchanged.
        drive(1'b1, 1'b1, 8'h40, 1'b0);
        tick("stall_flush");
        chk("stall_flush_pc", 32'(bus.pc), 32'h40);
        chk("stall_flush_ifid_valid", 32'(bus.ifid_valid), 32'd0);
        chk("stall_flush_bubbles", 32'(bus.bubble_count), 32'd1);

        // Silent pc wrap.
        seq_exp[0] = 8'hFE; seq_exp[1] = 8'hFF; seq_exp[2] = 8'h00; seq_exp[3] = 8'h01;
        drive(1'b0, 1'b1, 8'hFE, 1'b0);
        tick("wrap_flush");
        chk("wrap_pc0", 32'(bus.pc), 32'(seq_exp[0]));
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            tick("wrap");
            chk($sformatf("wrap_pc%0d", i), 32'(bus.pc), 32'(seq_exp[i]));
        end
        chk("wrap_err", 32'(bus.protocol_err), 32'd0);

        // Two consecutive stalls after a load: second one is illegal and sticky.
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick("load2_enter");
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick("stall2_a");
        chk("stall2_a_err", 32'(bus.protocol_err), 32'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick("stall2_b");
        chk("stall2_b_err", 32'(bus.protocol_err), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            tick("sticky");
        end
        chk("sticky_err", 32'(bus.protocol_err), 32'd1);
        do_reset();
        chk("err_cleared", 32'(bus.protocol_err), 32'd0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 250; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                  8'($urandom_range(0, 255)), 1'b0);
            tick("random");
        end

        // Mid-flush reset: pending flush discarded, restart from pc=0.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h99, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_mid_flush");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick("after_flush_reset");
        chk("after_flush_reset_pc", 32'(bus.pc), 32'd1);

        // Saturate the bubble counter with legal stalls.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            tick("prefill");
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            tick("sat_load");
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            tick("sat_stall");
        end
        chk("sat_bubbles", 32'(bus.bubble_count), 32'd255);
        chk("sat_err", 32'(bus.protocol_err), 32'd0);

        // Asynchronous reset in the middle of a stall cycle.
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick("pre_async_load");
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_mid_stall");
        chk("async_bubbles", 32'(bus.bubble_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick("post_async");
        chk("post_async_pc", 32'(bus.pc), 32'd1);
        chk("post_async_ex_valid", 32'(bus.ex_valid), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick("post_async2");
        chk("post_async2_ex_valid", 32'(bus.ex_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Parameters
REQ-001 SHALL provide PC_W, default 8, width of program counter and PC fields.
REQ-002 SHALL provide INSTR_W, default 8, width of fetched instruction.

Interface
REQ-003 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have stall  input  1  load-use stall request from hazard detection.
REQ-006 SHALL have flush  input  1  redirect request (taken branch/jump).
REQ-007 SHALL have flush_target  input  PC_W  next PC when flush=1.
REQ-008 SHALL have imem_instr  input  INSTR_W  instruction at current pc.
REQ-009 SHALL have id_mem_read, id_reg_write  input  1 each  decoded controls of IF/ID instruction.
REQ-010 SHALL have id_dest_reg, id_src_reg1, id_src_reg2  input  2 each  decoded register fields.
REQ-011 SHALL have pc  output  PC_W  current fetch address.
REQ-012 SHALL have ifid_valid  output  1, ifid_instr  output  INSTR_W, ifid_pc  output  PC_W  IF/ID register.
REQ-013 SHALL have ex_valid, ex_mem_read, ex_reg_write  output  1 each  ID/EX controls.
REQ-014 SHALL have ex_dest_reg, ex_src_reg1, ex_src_reg2  output  2 each  ID/EX register fields.
REQ-015 SHALL have bubble_count  output  8  stall-inserted bubbles, saturating.
REQ-016 SHALL have protocol_err  output  1  sticky illegal-stall flag.

Function
REQ-017 All outputs SHALL be registered; no combinational input-to-output path.
REQ-018 Normal cycle (stall=0, flush=0): pc<=pc+1 modulo 2^PC_W; IF/ID<={1, imem_instr, pc}; ID/EX<=ID fields with ex_valid<=ifid_valid.
REQ-019 When ifid_valid=0 in a normal cycle, ID/EX SHALL load a bubble: ex_valid, ex_mem_read, ex_reg_write and all register fields 0.
REQ-020 Stall cycle (stall=1, flush=0): pc and IF/ID SHALL hold; ID/EX SHALL load a bubble; bubble_count SHALL increment, saturating at 255.
REQ-021 Flush cycle (flush=1, any stall): pc<=flush_target; IF/ID<={0, 0, 0}; ID/EX<=bubble; bubble_count unchanged.
REQ-022 flush SHALL take priority over stall when both asserted in the same cycle.
REQ-023 protocol_err SHALL set on any edge where stall=1, flush=0 and ex_mem_read=0 (stall with no load in EX), and remain 1 until reset.
REQ-024 A legal load-use stall SHALL therefore last exactly one cycle; a second consecutive stall SHALL set protocol_err while still inserting a bubble per REQ-020.
REQ-025 Latency: an instruction presented on imem_instr at pc appears in IF/ID 1 cycle later and in ID/EX 2 cycles later, plus one cycle per stall.
REQ-026 pc wrap from 2^PC_W-1 to 0 SHALL be silent, with no flag.

Reset
REQ-027 rst=1 SHALL immediately force pc=0, IF/ID all 0, ID/EX all 0, bubble_count=0, protocol_err=0, independent of clk.
REQ-028 Reset asserted mid-stall or mid-flush SHALL discard the pending operation; first edge after release is a normal cycle from pc=0.
REQ-029 The first instruction after reset SHALL reach ex_valid=1 no earlier than the second rising edge after rst deasserts.

Verification
REQ-030 Reset release, stall=flush=0, 5 cycles -> pc=5, ifid_pc=4, ex_valid=1, bubble_count=0.
REQ-031 Load in IF/ID (id_mem_read=1, id_dest_reg=2), next cycle stall=1 for one cycle -> pc/ifid held one cycle, ex_valid=0, bubble_count=1, protocol_err=0.
REQ-032 stall=1 held two cycles after a load -> second edge sets protocol_err=1; it stays 1 through 10 further normal cycles until rst.
REQ-033 stall=1 and flush=1 together, flush_target=8'h40 -> pc=8'h40, ifid_valid=0, ex_valid=0, bubble_count unchanged.
REQ-034 pc preset near 8'hFF via flush_target=8'hFE, run 3 cycles -> pc sequence FE, FF, 00, 01.
REQ-035 300 legal stalls -> bubble_count=255 (saturated); rst asserted mid-stall, async -> all outputs 0 before next clk edge.
